// File: rtl/id_ex_stage_reg.sv
// -----------------------------------------------------------------------------
// id_ex_stage_reg
//   ID/EX pipeline register for the hardware-scheduled MIPS pipeline.
//   Carries the decoded ID fields (PC+4, operands, extended immediate,
//   register indices, load flag and the packed EX/MEM/WB control bundle)
//   into EX. The module also detects load-use hazards. When one is found it
//   holds PC and IF/ID upstream through o_load_use_stall and inserts exactly
//   one bubble into EX. An EX-side stall holds the register. A branch flush
//   squashes the incoming instruction to a bubble.
//
//   Per-edge priority: i_RST > i_flush > i_stall > hazard > capture.
//
// Ports
//   i_CLK, i_RST      clock; synchronous active-high reset
//   i_stall, i_flush  downstream hold / squash requests
//   i_id_*            decoded fields from ID
//   o_ex_*            registered fields presented to EX
//   o_load_use_stall  combinational hold request for PC and IF/ID
//   o_bubble_cnt      saturating count of hazard bubbles; present only when
//                     the BUBBLE_CNT_EN macro is defined
//
// Configuration macro: BUBBLE_CNT_EN
// -----------------------------------------------------------------------------
module id_ex_stage_reg #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CTRL_W     = 12,
  parameter int CNT_W      = 32
) (
  input  logic                  i_CLK,
  input  logic                  i_RST,
  input  logic                  i_stall,
  input  logic                  i_flush,
  input  logic                  i_id_valid,
  input  logic [DATA_WIDTH-1:0] i_id_pc,
  input  logic [DATA_WIDTH-1:0] i_id_rs_data,
  input  logic [DATA_WIDTH-1:0] i_id_rt_data,
  input  logic [DATA_WIDTH-1:0] i_id_imm,
  input  logic [REG_ADDR_W-1:0] i_id_rs_addr,
  input  logic [REG_ADDR_W-1:0] i_id_rt_addr,
  input  logic [REG_ADDR_W-1:0] i_id_rd_addr,
  input  logic                  i_id_uses_rt,
  input  logic                  i_id_mem_read,
  input  logic [CTRL_W-1:0]     i_id_ctrl,
  output logic                  o_ex_valid,
  output logic [DATA_WIDTH-1:0] o_ex_pc,
  output logic [DATA_WIDTH-1:0] o_ex_rs_data,
  output logic [DATA_WIDTH-1:0] o_ex_rt_data,
  output logic [DATA_WIDTH-1:0] o_ex_imm,
  output logic [REG_ADDR_W-1:0] o_ex_rs_addr,
  output logic [REG_ADDR_W-1:0] o_ex_rt_addr,
  output logic [REG_ADDR_W-1:0] o_ex_rd_addr,
  output logic                  o_ex_mem_read,
  output logic [CTRL_W-1:0]     o_ex_ctrl,
  output logic                  o_load_use_stall
`ifdef BUBBLE_CNT_EN
  ,
  output logic [CNT_W-1:0]      o_bubble_cnt
`endif
);

  logic                  vld_p1;
  logic [DATA_WIDTH-1:0] pc_p1;
  logic [DATA_WIDTH-1:0] rs_data_p1;
  logic [DATA_WIDTH-1:0] rt_data_p1;
  logic [DATA_WIDTH-1:0] imm_p1;
  logic [REG_ADDR_W-1:0] rs_addr_p1;
  logic [REG_ADDR_W-1:0] rt_addr_p1;
  logic [REG_ADDR_W-1:0] rd_addr_p1;
  logic                  mem_read_p1;
  logic [CTRL_W-1:0]     ctrl_p1;

  logic hazard;
  logic load_bubble;
  logic load_capture;

  // A load in EX whose destination (rt) is a source of the ID instruction.
  // $0 never carries a dependency.
  always_comb begin
    hazard = vld_p1 & mem_read_p1 & (rt_addr_p1 != '0) & i_id_valid &
             ((rt_addr_p1 == i_id_rs_addr) |
              (i_id_uses_rt & (rt_addr_p1 == i_id_rt_addr)));
  end

  // A flush already discards the ID instruction, so upstream need not hold.
  assign o_load_use_stall = hazard & ~i_flush & ~i_RST;

  // Flush beats stall. A hazard bubble waits for the first non-stalled edge.
  assign load_bubble  = i_flush | (~i_stall & hazard);
  assign load_capture = ~i_flush & ~i_stall & ~hazard;

  // ---- ID -> EX (p1) ----
  always_ff @(posedge i_CLK) begin
    if (i_RST || load_bubble) begin
      vld_p1      <= 1'b0;
      pc_p1       <= '0;
      rs_data_p1  <= '0;
      rt_data_p1  <= '0;
      imm_p1      <= '0;
      rs_addr_p1  <= '0;
      rt_addr_p1  <= '0;
      rd_addr_p1  <= '0;
      mem_read_p1 <= 1'b0;
      ctrl_p1     <= '0;
    end else if (load_capture) begin
      vld_p1      <= i_id_valid;
      pc_p1       <= i_id_pc;
      rs_data_p1  <= i_id_rs_data;
      rt_data_p1  <= i_id_rt_data;
      imm_p1      <= i_id_imm;
      rs_addr_p1  <= i_id_rs_addr;
      rt_addr_p1  <= i_id_rt_addr;
      rd_addr_p1  <= i_id_rd_addr;
      mem_read_p1 <= i_id_mem_read;
      ctrl_p1     <= i_id_ctrl;
    end
  end

  assign o_ex_valid    = vld_p1;
  assign o_ex_pc       = pc_p1;
  assign o_ex_rs_data  = rs_data_p1;
  assign o_ex_rt_data  = rt_data_p1;
  assign o_ex_imm      = imm_p1;
  assign o_ex_rs_addr  = rs_addr_p1;
  assign o_ex_rt_addr  = rt_addr_p1;
  assign o_ex_rd_addr  = rd_addr_p1;
  assign o_ex_mem_read = mem_read_p1;
  assign o_ex_ctrl     = ctrl_p1;

`ifdef BUBBLE_CNT_EN
  logic [CNT_W-1:0] bubble_cnt_p1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  // Counts only hazard bubbles. Flush bubbles and stalled edges are excluded.
  always_ff @(posedge i_CLK) begin
    if (i_RST)
      bubble_cnt_p1 <= '0;
    else if (~i_flush & ~i_stall & hazard)
      bubble_cnt_p1 <= sat_inc(bubble_cnt_p1);
  end

  assign o_bubble_cnt = bubble_cnt_p1;
`endif

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// -----------------------------------------------------------------------------
// tb_id_ex_stage_reg
//   Self-checking bench for id_ex_stage_reg. A table of directed vectors
//   carries hand-derived expectations. A randomized run follows. A
//   behavioural model of the EX register contents checks every cycle.
// -----------------------------------------------------------------------------
module tb_id_ex_stage_reg;

  localparam int CNT_W_TB = 3;

  typedef struct {
    logic        rst, stall, flush, valid;
    logic [31:0] pc, rs_data, rt_data, imm;
    logic [4:0]  rs, rt, rd;
    logic        uses_rt, mem_read;
    logic [11:0] ctrl;
  } in_t;

  typedef struct {
    logic        valid;
    logic [31:0] pc, rs_data, rt_data, imm;
    logic [4:0]  rs, rt, rd;
    logic        mem_read;
    logic [11:0] ctrl;
  } ex_t;

  typedef struct {
    in_t         in;
    logic        exp_stall;
    logic        exp_valid;
    logic [31:0] exp_imm;
    logic [4:0]  exp_rd;
    logic [11:0] exp_ctrl;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst, stall, flush, id_valid, id_uses_rt, id_mem_read;
  logic [31:0] id_pc, id_rs_data, id_rt_data, id_imm;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [11:0] id_ctrl;
  logic        ex_valid, ex_mem_read, load_use_stall;
  logic [31:0] ex_pc, ex_rs_data, ex_rt_data, ex_imm;
  logic [4:0]  ex_rs, ex_rt, ex_rd;
  logic [11:0] ex_ctrl;
`ifdef BUBBLE_CNT_EN
  logic [CNT_W_TB-1:0] bubble_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  ex_t m;          // model of what EX should hold
  int  m_cnt = 0;  // model of the hazard-bubble counter
  vec_t vecs[$];

  always #5 clk = ~clk;

  id_ex_stage_reg #(
    .DATA_WIDTH(32), .REG_ADDR_W(5), .CTRL_W(12), .CNT_W(CNT_W_TB)
  ) dut (
    .i_CLK(clk), .i_RST(rst), .i_stall(stall), .i_flush(flush),
    .i_id_valid(id_valid), .i_id_pc(id_pc), .i_id_rs_data(id_rs_data),
    .i_id_rt_data(id_rt_data), .i_id_imm(id_imm), .i_id_rs_addr(id_rs),
    .i_id_rt_addr(id_rt), .i_id_rd_addr(id_rd), .i_id_uses_rt(id_uses_rt),
    .i_id_mem_read(id_mem_read), .i_id_ctrl(id_ctrl),
    .o_ex_valid(ex_valid), .o_ex_pc(ex_pc), .o_ex_rs_data(ex_rs_data),
    .o_ex_rt_data(ex_rt_data), .o_ex_imm(ex_imm), .o_ex_rs_addr(ex_rs),
    .o_ex_rt_addr(ex_rt), .o_ex_rd_addr(ex_rd), .o_ex_mem_read(ex_mem_read),
    .o_ex_ctrl(ex_ctrl), .o_load_use_stall(load_use_stall)
`ifdef BUBBLE_CNT_EN
    , .o_bubble_cnt(bubble_cnt)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic in_t mkin(input logic r, s, f, v, input logic [31:0] pc, imm,
                               input logic [4:0] rs, rt, rd, input logic ur, mr,
                               input logic [11:0] ctrl);
    in_t x;
    x.rst = r; x.stall = s; x.flush = f; x.valid = v;
    x.pc = pc; x.imm = imm;
    x.rs_data = imm ^ 32'h5A5A_5A5A;
    x.rt_data = ~pc;
    x.rs = rs; x.rt = rt; x.rd = rd;
    x.uses_rt = ur; x.mem_read = mr; x.ctrl = ctrl;
    return x;
  endfunction

  function automatic in_t rnd_in();
    in_t x;
    x.rst      = ($urandom_range(0, 49) == 0);
    x.stall    = ($urandom_range(0, 4) == 0);
    x.flush    = ($urandom_range(0, 7) == 0);
    x.valid    = ($urandom_range(0, 7) != 0);
    x.pc       = $urandom;
    x.rs_data  = $urandom;
    x.rt_data  = $urandom;
    x.imm      = $urandom;
    x.rs       = 5'($urandom_range(0, 3));
    x.rt       = 5'($urandom_range(0, 3));
    x.rd       = 5'($urandom);
    x.uses_rt  = 1'($urandom);
    x.mem_read = ($urandom_range(0, 2) == 0);
    x.ctrl     = 12'($urandom);
    return x;
  endfunction

  // A load in EX blocks an ID instruction that reads its destination (not $0).
  function automatic logic model_hazard(input ex_t e, input in_t x);
    if (!(e.valid && e.mem_read && e.rt != 0 && x.valid)) return 1'b0;
    return (e.rt == x.rs) || (x.uses_rt && e.rt == x.rt);
  endfunction

  // One cycle: drive, check the combinational stall, clock, then check EX.
  task automatic cycle(input in_t x, output logic got_stall);
    ex_t  nxt;
    ex_t  bubble;
    logic hz;
    @(negedge clk);
    rst = x.rst; stall = x.stall; flush = x.flush; id_valid = x.valid;
    id_pc = x.pc; id_rs_data = x.rs_data; id_rt_data = x.rt_data; id_imm = x.imm;
    id_rs = x.rs; id_rt = x.rt; id_rd = x.rd; id_uses_rt = x.uses_rt;
    id_mem_read = x.mem_read; id_ctrl = x.ctrl;
    #1;
    hz = model_hazard(m, x);
    got_stall = load_use_stall;
    chk("load_use_stall", {31'd0, load_use_stall}, {31'd0, hz && !x.flush && !x.rst});
    bubble = '{default: '0};
    nxt = m;
    if (x.rst) begin
      nxt = bubble; m_cnt = 0;
    end else if (x.flush) begin
      nxt = bubble;
    end else if (x.stall) begin
      nxt = m;
    end else if (hz) begin
      nxt = bubble;
      if (m_cnt < (1 << CNT_W_TB) - 1) m_cnt++;
    end else begin
      nxt.valid = x.valid; nxt.pc = x.pc; nxt.rs_data = x.rs_data;
      nxt.rt_data = x.rt_data; nxt.imm = x.imm; nxt.rs = x.rs; nxt.rt = x.rt;
      nxt.rd = x.rd; nxt.mem_read = x.mem_read; nxt.ctrl = x.ctrl;
    end
    m = nxt;
    @(posedge clk);
    #1;
    chk("ex_valid",    {31'd0, ex_valid},    {31'd0, m.valid});
    chk("ex_pc",       ex_pc,                m.pc);
    chk("ex_rs_data",  ex_rs_data,           m.rs_data);
    chk("ex_rt_data",  ex_rt_data,           m.rt_data);
    chk("ex_imm",      ex_imm,               m.imm);
    chk("ex_rs_addr",  {27'd0, ex_rs},       {27'd0, m.rs});
    chk("ex_rt_addr",  {27'd0, ex_rt},       {27'd0, m.rt});
    chk("ex_rd_addr",  {27'd0, ex_rd},       {27'd0, m.rd});
    chk("ex_mem_read", {31'd0, ex_mem_read}, {31'd0, m.mem_read});
    chk("ex_ctrl",     {20'd0, ex_ctrl},     {20'd0, m.ctrl});
`ifdef BUBBLE_CNT_EN
    chk("bubble_cnt",  32'(bubble_cnt),      32'(m_cnt));
`endif
  endtask

  initial begin
    logic st;
    m = '{default: '0};
    rst = 1'b1; stall = 1'b0; flush = 1'b0; id_valid = 1'b0; id_uses_rt = 1'b0;
    id_mem_read = 1'b0; id_pc = '0; id_rs_data = '0; id_rt_data = '0; id_imm = '0;
    id_rs = '0; id_rt = '0; id_rd = '0; id_ctrl = '0;

    //                 rst stl fls vld pc            imm           rs  rt  rd  urt mr  ctrl      stall valid imm           rd     ctrl
    // reset with junk inputs
    vecs.push_back('{mkin(1,0,0,1, 32'h1111_2222, 32'h1234_5678, 9, 9, 9, 1,1, 12'hFFF), 0, 0, 32'h0,         5'd0,  12'h000});
    vecs.push_back('{mkin(1,1,0,1, 32'h3333_4444, 32'h9ABC_DEF0, 3, 4, 5, 1,1, 12'hABC), 0, 0, 32'h0,         5'd0,  12'h000});
    // capture with sign-extended immediate
    vecs.push_back('{mkin(0,0,0,1, 32'h0040_0004, 32'hFFFF_8000, 1, 2, 8, 0,0, 12'h0A5), 0, 1, 32'hFFFF_8000, 5'd8,  12'h0A5});
    // lw rt=9, then add rs=9: one bubble, then add captured
    vecs.push_back('{mkin(0,0,0,1, 32'h0040_0008, 32'h0000_0004, 29, 9, 9, 0,1, 12'h111), 0, 1, 32'h4,         5'd9,  12'h111});
    vecs.push_back('{mkin(0,0,0,1, 32'h0040_000C, 32'h0000_0000, 9, 10, 11, 1,0, 12'h222), 1, 0, 32'h0,        5'd0,  12'h000});
    vecs.push_back('{mkin(0,0,0,1, 32'h0040_000C, 32'h0000_0000, 9, 10, 11, 1,0, 12'h222), 0, 1, 32'h0,        5'd11, 12'h222});
    // rt match with uses_rt=0: no stall
    vecs.push_back('{mkin(0,0,0,1, 32'h0040_0010, 32'h0000_0004, 29, 9, 9, 0,1, 12'h111), 0, 1, 32'h4,         5'd9,  12'h111});
    vecs.push_back('{mkin(0,0,0,1, 32'h0040_0014, 32'h0000_0007, 3, 9, 12, 0,0, 12'h333), 0, 1, 32'h7,         5'd12, 12'h333});
    // rt match with uses_rt=1: stall
    vecs.push_back('{mkin(0,0,0,1, 32'h0040_0018, 32'h0000_0004, 29, 9, 9, 0,1, 12'h111), 0, 1, 32'h4,         5'd9,  12'h111});
    vecs.push_back('{mkin(0,0,0,1, 32'h0040_001C, 32'h0000_0007, 3, 9, 12, 1,0, 12'h333), 1, 0, 32'h0,         5'd0,  12'h000});
    // load into $0 then rs=0: no stall
    vecs.push_back('{mkin(0,0,0,1, 32'h0040_0020, 32'h0000_0005, 29, 0, 0, 0,1, 12'h444), 0, 1, 32'h5,         5'd0,  12'h444});
    vecs.push_back('{mkin(0,0,0,1, 32'h0040_0024, 32'h0000_0006, 0, 0, 13, 1,0, 12'h555), 0, 1, 32'h6,         5'd13, 12'h555});
    // hazard with flush: no stall, bubble
    vecs.push_back('{mkin(0,0,0,1, 32'h0040_0028, 32'h0000_0008, 29, 9, 9, 0,1, 12'h666), 0, 1, 32'h8,         5'd9,  12'h666});
    vecs.push_back('{mkin(0,0,1,1, 32'h0040_002C, 32'h0000_0001, 9, 1, 14, 1,0, 12'h123), 0, 0, 32'h0,         5'd0,  12'h000});
    // stall 3 cycles while ID changes, then flush with stall
    vecs.push_back('{mkin(0,0,0,1, 32'h0040_0030, 32'hAAAA_0000, 1, 2, 14, 1,0, 12'h777), 0, 1, 32'hAAAA_0000, 5'd14, 12'h777});
    vecs.push_back('{mkin(0,1,0,1, 32'h0040_0034, 32'h0000_0011, 2, 3, 15, 1,1, 12'h001), 0, 1, 32'hAAAA_0000, 5'd14, 12'h777});
    vecs.push_back('{mkin(0,1,0,0, 32'h0040_0038, 32'h0000_0022, 3, 4, 16, 0,0, 12'h002), 0, 1, 32'hAAAA_0000, 5'd14, 12'h777});
    vecs.push_back('{mkin(0,1,0,1, 32'h0040_003C, 32'h0000_0033, 4, 5, 17, 1,1, 12'h003), 0, 1, 32'hAAAA_0000, 5'd14, 12'h777});
    vecs.push_back('{mkin(0,1,1,1, 32'h0040_0040, 32'h0000_0044, 5, 6, 18, 1,0, 12'h004), 0, 0, 32'h0,         5'd0,  12'h000});
    // stall with hazard: held, stall output stays high, bubble on the next free edge
    vecs.push_back('{mkin(0,0,0,1, 32'h0040_0044, 32'h0000_0009, 29, 9, 9, 0,1, 12'h888), 0, 1, 32'h9,         5'd9,  12'h888});
    vecs.push_back('{mkin(0,1,0,1, 32'h0040_0048, 32'h0000_000A, 9, 1, 19, 0,0, 12'h999), 1, 1, 32'h9,         5'd9,  12'h888});
    vecs.push_back('{mkin(0,0,0,1, 32'h0040_0048, 32'h0000_000A, 9, 1, 19, 0,0, 12'h999), 1, 0, 32'h0,         5'd0,  12'h000});
    vecs.push_back('{mkin(0,0,0,1, 32'h0040_0048, 32'h0000_000A, 9, 1, 19, 0,0, 12'h999), 0, 1, 32'hA,         5'd19, 12'h999});
    // reset mid-hazard: clears, nothing replayed
    vecs.push_back('{mkin(0,0,0,1, 32'h0040_004C, 32'h0000_000B, 29, 9, 9, 0,1, 12'hBBB), 0, 1, 32'hB,         5'd9,  12'hBBB});
    vecs.push_back('{mkin(1,0,0,1, 32'h0040_0050, 32'h0000_000C, 9, 1, 20, 0,0, 12'hCCC), 0, 0, 32'h0,         5'd0,  12'h000});
    vecs.push_back('{mkin(0,0,0,1, 32'h0040_0050, 32'h0000_000C, 9, 1, 20, 0,0, 12'hCCC), 0, 1, 32'hC,         5'd20, 12'hCCC});

    foreach (vecs[i]) begin
      cycle(vecs[i].in, st);
      chk($sformatf("vec%0d stall", i), {31'd0, st},       {31'd0, vecs[i].exp_stall});
      chk($sformatf("vec%0d valid", i), {31'd0, ex_valid}, {31'd0, vecs[i].exp_valid});
      chk($sformatf("vec%0d imm", i),   ex_imm,            vecs[i].exp_imm);
      chk($sformatf("vec%0d rd", i),    {27'd0, ex_rd},    {27'd0, vecs[i].exp_rd});
      chk($sformatf("vec%0d ctrl", i),  {20'd0, ex_ctrl},  {20'd0, vecs[i].exp_ctrl});
    end

    // Randomized traffic against the model; narrow register indices make
    // hazards frequent and the small counter reaches saturation.
    for (int i = 0; i < 3000; i++) begin
      cycle(rnd_in(), st);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
